fb_plot_sink: RTL



---
 rtl/fb_plot_sink_pkg.sv | 22 ++
 rtl/fb_plot_sink_plot_fifo.sv | 67 ++++++
 rtl/fb_plot_sink.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fb_plot_sink_pkg.sv
// fb_plot_sink_pkg
//   Frame constants and FSM encoding shared by the drawing engines and the
//   framebuffer plot sink, plus the default-frame pixel address helper.
package fb_plot_sink_pkg;

  localparam int FB_WIDTH       = 160;
  localparam int FB_HEIGHT      = 120;
  localparam int FB_COLOUR_BITS = 3;
  localparam int FB_ADDR_W      = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] px,
                                                   input logic [6:0] py);
    return (FB_ADDR_W'(py) << 7) + (FB_ADDR_W'(py) << 5) + FB_ADDR_W'(px);
  endfunction

endpackage

// File: rtl/fb_plot_sink_plot_fifo.sv
// plot_fifo
//   Synchronous FIFO with combinational head read-out.
//   clock/resetn : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata   : enqueue; ignored when full unless a pop happens together
//   pop/rdata    : dequeue the head; rdata always shows the head entry
//   full/empty/count : occupancy
//   DEPTH must be a power of two, at least 2.
module plot_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 18
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it maps onto plain distributed RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fb_plot_sink.sv
// fb_plot_sink
//   Framebuffer write endpoint: buffers plot strobes in a FIFO, writes them to
//   a single-port WIDTH x HEIGHT framebuffer, serves a priority scan-out read
//   port and performs a hardware full-screen clear.
//   clock/resetn              : clock, asynchronous active-low reset
//   plot/x/y/colour           : plot request (one per cycle while plot=1)
//   rd_req/rd_x/rd_y          : scan-out read; rd_colour/rd_valid one cycle later
//   clear/clear_colour/busy   : start a fill; busy while the fill runs
//   fifo_count                : buffered plots
//   overflow/oob_err/err_clr  : sticky drop flags and their clear
module fb_plot_sink
  import fb_plot_sink_pkg::*;
#(
  parameter int WIDTH       = FB_WIDTH,
  parameter int HEIGHT      = FB_HEIGHT,
  parameter int COLOUR_BITS = FB_COLOUR_BITS,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          plot,
  input  logic [7:0]                    x,
  input  logic [6:0]                    y,
  input  logic [COLOUR_BITS-1:0]        colour,
  input  logic                          rd_req,
  input  logic [7:0]                    rd_x,
  input  logic [6:0]                    rd_y,
  output logic [COLOUR_BITS-1:0]        rd_colour,
  output logic                          rd_valid,
  input  logic                          clear,
  input  logic [COLOUR_BITS-1:0]        clear_colour,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          oob_err,
  input  logic                          err_clr
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int DATA_W = FB_ADDR_W + COLOUR_BITS;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(NPIX - 1);

  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [7:0] px,
                                                    input logic [6:0] py);
    if (WIDTH == FB_WIDTH) return fb_addr(px, py);
    return FB_ADDR_W'(int'(py) * WIDTH + int'(px));
  endfunction

  // ---------------------------------------------------------------- plot side
  logic                  plot_in_range, rd_in_range;
  logic [FB_ADDR_W-1:0]  plot_addr, rd_addr;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]     fifo_rdata;
  logic                  oob_drop, ovf_drop;

  assign plot_in_range = ({1'b0, x} < 9'(WIDTH)) && ({2'b0, y} < 9'(HEIGHT));
  assign rd_in_range   = ({1'b0, rd_x} < 9'(WIDTH)) && ({2'b0, rd_y} < 9'(HEIGHT));
  assign plot_addr     = pix_addr(x, y);
  // Out-of-range reads are steered to address 0 and masked on the way out.
  assign rd_addr       = rd_in_range ? pix_addr(rd_x, rd_y) : '0;

  fb_state_e state_q, state_d;

  // Pops only in IDLE so plots issued during a clear land on top of it.
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !rd_req;
  assign fifo_push = plot && plot_in_range && (!fifo_full || fifo_pop);
  assign oob_drop  = plot && !plot_in_range;
  assign ovf_drop  = plot && plot_in_range && fifo_full && !fifo_pop;

  plot_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_plot_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  ({plot_addr, colour}),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // ---------------------------------------------------------------- control
  logic [FB_ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [COLOUR_BITS-1:0] clr_colour_q, clr_colour_d;
  logic busy_q, busy_d;
  logic overflow_q, overflow_d;
  logic oob_q, oob_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_oob_q, rd_oob_d;

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_colour_d = clr_colour_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          clr_colour_d = clear_colour;
          clr_addr_d   = '0;
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        // A read steals the port, so the clear only advances on free cycles.
        if (!rd_req) begin
          if (clr_addr_q == LAST_ADDR) begin
            clr_addr_d = '0;
            state_d    = IDLE;
          end else begin
            clr_addr_d = clr_addr_q + FB_ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == CLEAR);
    // A drop on the same edge as err_clr keeps the flag set.
    overflow_d = ovf_drop || (overflow_q && !err_clr);
    oob_d      = oob_drop || (oob_q && !err_clr);
    rd_valid_d = rd_req;
    rd_oob_d   = rd_req && !rd_in_range;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      clr_colour_q <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      oob_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_oob_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_colour_q <= clr_colour_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      oob_q        <= oob_d;
      rd_valid_q   <= rd_valid_d;
      rd_oob_q     <= rd_oob_d;
    end
  end

  // ---------------------------------------------------------------- RAM port
  logic                   ram_we;
  logic [FB_ADDR_W-1:0]   ram_addr;
  logic [COLOUR_BITS-1:0] ram_wdata;
  logic [COLOUR_BITS-1:0] ram_rdata_q;
  logic [COLOUR_BITS-1:0] mem [0:NPIX-1];

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = clr_colour_q;
    if (rd_req) begin
      ram_addr = rd_addr;
    end else if (state_q == CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr_q;
    end else if (fifo_pop) begin
      ram_we    = 1'b1;
      ram_addr  = fifo_rdata[DATA_W-1:COLOUR_BITS];
      ram_wdata = fifo_rdata[COLOUR_BITS-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata_q <= mem[ram_addr];
  end

  // The RAM output register has no reset; the resettable valid/oob flags
  // force the visible colour to 0 after reset and for out-of-range reads.
  assign rd_colour = (rd_valid_q && !rd_oob_q) ? ram_rdata_q : '0;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign oob_err   = oob_q;

endmodule
